// File: rtl/bp_me_pkg.sv
// Shared BedRock mem message types, responder FSM states and the beat-count helper
// for the accelerator uncached responder.
package bp_me_pkg;

    localparam int paddr_width_gp        = 40;
    localparam int payload_width_gp      = 16;
    localparam int bedrock_fill_width_gp = 64;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [payload_width_gp-1:0] payload;
        bp_bedrock_msg_size_e        size;
        logic [paddr_width_gp-1:0]   addr;
        logic [3:0]                  subop;
        bp_bedrock_mem_type_e        msg_type;
    } bp_bedrock_mem_header_s;

    localparam int mem_header_width_gp = $bits(bp_bedrock_mem_header_s);

    typedef enum logic [1:0] {
        e_ready,
        e_wr_data,
        e_wr_resp,
        e_rd_resp
    } bp_me_accel_resp_state_e;

    // Messages narrower than a fill beat still occupy one beat
    function automatic logic [7:0] bedrock_beats(input bp_bedrock_msg_size_e size,
                                                 input int fill_width);
        int bits;
        bits = (1 << size) * 8;
        return (bits <= fill_width) ? 8'd1 : 8'(bits / fill_width);
    endfunction

endpackage

// File: rtl/bp_me_accel_scratchpad.sv
// Flop-based scratchpad: one byte-masked write port, one combinational read port.
// Contents are intentionally not reset.
module bp_me_accel_scratchpad #(
    parameter int width_p = 64,
    parameter int els_p   = 64
) (
    input  logic                       clk_i,
    input  logic                       w_v,
    input  logic [$clog2(els_p)-1:0]   w_addr,
    input  logic [width_p-1:0]         w_data,
    input  logic [width_p/8-1:0]       w_mask,
    input  logic [$clog2(els_p)-1:0]   r_addr,
    output logic [width_p-1:0]         r_data
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v) begin
            for (int i = 0; i < width_p/8; i++) begin
                if (w_mask[i]) begin
                    mem[w_addr][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/bp_me_accel_uc_responder.sv
// L2-side responder for accelerator uncached BedRock traffic: stores uc writes in a
// local scratchpad, returns write acks and multi-beat read data.
module bp_me_accel_uc_responder
    import bp_me_pkg::*;
#(
    parameter int fill_width_p = bedrock_fill_width_gp,
    parameter int els_p        = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [mem_header_width_gp-1:0] mem_fwd_header_i,
    input  logic [fill_width_p-1:0]        mem_fwd_data_i,
    input  logic                           mem_fwd_v_i,
    output logic                           mem_fwd_ready_and_o,
    output logic [mem_header_width_gp-1:0] mem_rev_header_o,
    output logic [fill_width_p-1:0]        mem_rev_data_o,
    output logic                           mem_rev_v_o,
    input  logic                           mem_rev_ready_and_i,
    output logic                           error_o
);

    localparam int fill_bytes_lp  = fill_width_p / 8;
    localparam int byte_off_w_lp  = $clog2(fill_bytes_lp);
    localparam int idx_w_lp       = $clog2(els_p);

    bp_me_accel_resp_state_e state_r, state_n;
    bp_bedrock_mem_header_s  fwd_hdr, header_r;
    logic [idx_w_lp-1:0]     idx_r, fwd_idx, wr_idx, rd_idx;
    logic [7:0]              beat_r, beats_r, fwd_beats, load_beat;
    logic                    error_r, set_error, load, beat_inc, wr_v;
    logic [fill_bytes_lp-1:0] sub_mask, wr_mask;
    logic [fill_width_p-1:0] rd_data;
    int                      fwd_off, fwd_bytes;

    assign fwd_hdr   = bp_bedrock_mem_header_s'(mem_fwd_header_i);
    assign fwd_idx   = fwd_hdr.addr[byte_off_w_lp +: idx_w_lp];
    assign fwd_beats = bedrock_beats(fwd_hdr.size, fill_width_p);
    assign fwd_off   = int'(fwd_hdr.addr[byte_off_w_lp-1:0]);
    assign fwd_bytes = 1 << fwd_hdr.size;
    assign rd_idx    = idx_r + beat_r[idx_w_lp-1:0];

    // Sub-fill writes only touch the addressed bytes; full-fill writes touch all
    always_comb begin
        sub_mask = '0;
        for (int i = 0; i < fill_bytes_lp; i++) begin
            sub_mask[i] = (fwd_bytes >= fill_bytes_lp)
                       || ((i >= fwd_off) && (i < fwd_off + fwd_bytes));
        end
    end

    always_comb begin
        state_n             = state_r;
        mem_fwd_ready_and_o = 1'b0;
        mem_rev_v_o         = 1'b0;
        wr_v                = 1'b0;
        wr_idx              = rd_idx;
        wr_mask             = '1;
        load                = 1'b0;
        load_beat           = 8'd0;
        beat_inc            = 1'b0;
        set_error           = 1'b0;
        case (state_r)
            e_ready: begin
                mem_fwd_ready_and_o = 1'b1;
                if (mem_fwd_v_i) begin
                    load = 1'b1;
                    case (fwd_hdr.msg_type)
                        e_bedrock_mem_uc_wr: begin
                            wr_v      = 1'b1;
                            wr_idx    = fwd_idx;
                            wr_mask   = sub_mask;
                            load_beat = 8'd1;
                            state_n   = (fwd_beats == 8'd1) ? e_wr_resp : e_wr_data;
                        end
                        e_bedrock_mem_uc_rd: state_n = e_rd_resp;
                        default: begin
                            set_error = 1'b1;
                            state_n   = e_wr_resp;
                        end
                    endcase
                end
            end
            e_wr_data: begin
                mem_fwd_ready_and_o = 1'b1;
                if (mem_fwd_v_i) begin
                    wr_v     = 1'b1;
                    beat_inc = 1'b1;
                    if (beat_r == beats_r - 8'd1) state_n = e_wr_resp;
                end
            end
            e_wr_resp: begin
                mem_rev_v_o = 1'b1;
                if (mem_rev_ready_and_i) state_n = e_ready;
            end
            e_rd_resp: begin
                mem_rev_v_o = 1'b1;
                if (mem_rev_ready_and_i) begin
                    beat_inc = 1'b1;
                    if (beat_r == beats_r - 8'd1) state_n = e_ready;
                end
            end
            default: state_n = e_ready;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_ready;
            header_r <= '0;
            idx_r    <= '0;
            beat_r   <= 8'd0;
            beats_r  <= 8'd0;
            error_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            error_r <= error_r | set_error;
            if (load) begin
                header_r <= fwd_hdr;
                idx_r    <= fwd_idx;
                beats_r  <= fwd_beats;
                beat_r   <= load_beat;
            end else if (beat_inc) begin
                beat_r <= beat_r + 8'd1;
            end
        end
    end

    bp_me_accel_scratchpad #(
        .width_p(fill_width_p),
        .els_p  (els_p)
    ) scratchpad (
        .clk_i (clk_i),
        .w_v   (wr_v),
        .w_addr(wr_idx),
        .w_data(mem_fwd_data_i),
        .w_mask(wr_mask),
        .r_addr(rd_idx),
        .r_data(rd_data)
    );

    assign mem_rev_header_o = header_r;
    assign mem_rev_data_o   = (state_r == e_rd_resp) ? rd_data : '0;
    assign error_o          = error_r;

endmodule

// File: tb/tb_bp_me_accel_uc_responder.sv
// Directed self-checking bench for bp_me_accel_uc_responder (fill width 64, 64 entries).
module tb_bp_me_accel_uc_responder;
    import bp_me_pkg::*;

    logic                           clk_i = 1'b0;
    logic                           reset_i = 1'b1;
    logic [mem_header_width_gp-1:0] mem_fwd_header_i = '0;
    logic [63:0]                    mem_fwd_data_i = '0;
    logic                           mem_fwd_v_i = 1'b0;
    logic                           mem_fwd_ready_and_o;
    logic [mem_header_width_gp-1:0] mem_rev_header_o;
    logic [63:0]                    mem_rev_data_o;
    logic                           mem_rev_v_o;
    logic                           mem_rev_ready_and_i = 1'b0;
    logic                           error_o;

    int asserts  = 0;
    int failures = 0;

    bp_me_accel_uc_responder #(.fill_width_p(64), .els_p(64)) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .mem_fwd_header_i   (mem_fwd_header_i),
        .mem_fwd_data_i     (mem_fwd_data_i),
        .mem_fwd_v_i        (mem_fwd_v_i),
        .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
        .mem_rev_header_o   (mem_rev_header_o),
        .mem_rev_data_o     (mem_rev_data_o),
        .mem_rev_v_o        (mem_rev_v_o),
        .mem_rev_ready_and_i(mem_rev_ready_and_i),
        .error_o            (error_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic bp_bedrock_mem_header_s mk_hdr(input bp_bedrock_mem_type_e t,
                                                      input logic [39:0] a,
                                                      input bp_bedrock_msg_size_e s,
                                                      input logic [15:0] p);
        bp_bedrock_mem_header_s h;
        h.msg_type = t;
        h.subop    = 4'h3;
        h.addr     = a;
        h.size     = s;
        h.payload  = p;
        return h;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one fwd beat and return just after its handshake edge
    task automatic send_beat(input bp_bedrock_mem_header_s h, input logic [63:0] d);
        int n;
        mem_fwd_header_i = h;
        mem_fwd_data_i   = d;
        mem_fwd_v_i      = 1'b1;
        n = 0;
        while (!mem_fwd_ready_and_o && n < 20) begin
            tick();
            n++;
        end
        asserts++;
        if (!mem_fwd_ready_and_o) begin
            failures++;
            $display("[TB] FAIL fwd_timeout: ready_and=%0b required 1", mem_fwd_ready_and_o);
        end
        tick();
        mem_fwd_v_i = 1'b0;
    endtask

    // Accept one rev beat, checking header and data
    task automatic recv_beat(input string name, input bp_bedrock_mem_header_s h,
                             input logic [63:0] d);
        int n;
        n = 0;
        while (!mem_rev_v_o && n < 20) begin
            tick();
            n++;
        end
        asserts++;
        if (!mem_rev_v_o) begin
            failures++;
            $display("[TB] FAIL %s_rev_timeout: rev_v=%0b required 1", name, mem_rev_v_o);
        end
        asserts++;
        if (mem_rev_header_o !== h) begin
            failures++;
            $display("[TB] FAIL %s_hdr: got %h required %h", name, mem_rev_header_o, h);
        end
        asserts++;
        if (mem_rev_data_o !== d) begin
            failures++;
            $display("[TB] FAIL %s_data: got %h required %h", name, mem_rev_data_o, d);
        end
        mem_rev_ready_and_i = 1'b1;
        tick();
        mem_rev_ready_and_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        asserts++;
        if (mem_fwd_ready_and_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b required 1", mem_fwd_ready_and_o);
        end
        asserts++;
        if (mem_rev_v_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_rev_v: got %b required 0", mem_rev_v_o);
        end
        asserts++;
        if (error_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_error: got %b required 0", error_o);
        end
    endtask

    task automatic test_write_read();
        bp_bedrock_mem_header_s w, r;
        w = mk_hdr(e_bedrock_mem_uc_wr, 40'h100, e_bedrock_msg_size_16, 16'hA001);
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h100, e_bedrock_msg_size_16, 16'hA002);
        send_beat(w, 64'hAAAA_AAAA_AAAA_AAAA);
        asserts++;
        if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wr_mid: rev_v=%b ready=%b required 0/1", mem_rev_v_o,
                     mem_fwd_ready_and_o);
        end
        send_beat(w, 64'hBBBB_BBBB_BBBB_BBBB);
        asserts++;
        if (mem_rev_v_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wr_ack_latency: rev_v=%b required 1", mem_rev_v_o);
        end
        recv_beat("wr_ack", w, 64'h0);
        send_beat(r, 64'h0);
        asserts++;
        if (mem_rev_v_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rd_latency: rev_v=%b required 1", mem_rev_v_o);
        end
        recv_beat("rd_b0", r, 64'hAAAA_AAAA_AAAA_AAAA);
        recv_beat("rd_b1", r, 64'hBBBB_BBBB_BBBB_BBBB);
        asserts++;
        if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rd_done: rev_v=%b ready=%b required 0/1", mem_rev_v_o,
                     mem_fwd_ready_and_o);
        end
    endtask

    task automatic test_wrap();
        bp_bedrock_mem_header_s w, r;
        w = mk_hdr(e_bedrock_mem_uc_wr, 40'h1F8, e_bedrock_msg_size_16, 16'hB001);
        send_beat(w, 64'h1111_1111_1111_1111);
        send_beat(w, 64'h2222_2222_2222_2222);
        recv_beat("wrap_ack", w, 64'h0);
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h1F8, e_bedrock_msg_size_8, 16'hB002);
        send_beat(r, 64'h0);
        recv_beat("wrap_e63", r, 64'h1111_1111_1111_1111);
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h000, e_bedrock_msg_size_8, 16'hB003);
        send_beat(r, 64'h0);
        recv_beat("wrap_e0", r, 64'h2222_2222_2222_2222);
    endtask

    task automatic test_subfill();
        bp_bedrock_mem_header_s w, r;
        w = mk_hdr(e_bedrock_mem_uc_wr, 40'h103, e_bedrock_msg_size_1, 16'hC001);
        send_beat(w, 64'hFFFF_FFFF_5AFF_FFFF);
        recv_beat("sub_ack", w, 64'h0);
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h100, e_bedrock_msg_size_8, 16'hC002);
        send_beat(r, 64'h0);
        recv_beat("sub_rd", r, 64'hAAAA_AAAA_5AAA_AAAA);
    endtask

    task automatic test_backpressure();
        bp_bedrock_mem_header_s r;
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h100, e_bedrock_msg_size_16, 16'hD001);
        send_beat(r, 64'h0);
        for (int i = 0; i < 5; i++) begin
            asserts++;
            if (mem_rev_v_o !== 1'b1 || mem_fwd_ready_and_o !== 1'b0 ||
                mem_rev_header_o !== r || mem_rev_data_o !== 64'hAAAA_AAAA_5AAA_AAAA) begin
                failures++;
                $display("[TB] FAIL stall_%0d: rev_v=%b ready=%b hdr=%h data=%h", i,
                         mem_rev_v_o, mem_fwd_ready_and_o, mem_rev_header_o, mem_rev_data_o);
            end
            tick();
        end
        recv_beat("bp_b0", r, 64'hAAAA_AAAA_5AAA_AAAA);
        recv_beat("bp_b1", r, 64'hBBBB_BBBB_BBBB_BBBB);
    endtask

    task automatic test_amo_error();
        bp_bedrock_mem_header_s a, r;
        a = mk_hdr(e_bedrock_mem_amo, 40'h100, e_bedrock_msg_size_8, 16'hE001);
        send_beat(a, 64'hDEAD_BEEF_DEAD_BEEF);
        asserts++;
        if (error_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL amo_error_set: got %b required 1", error_o);
        end
        recv_beat("amo_ack", a, 64'h0);
        repeat (3) tick();
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h100, e_bedrock_msg_size_8, 16'hE002);
        send_beat(r, 64'h0);
        recv_beat("amo_unchanged", r, 64'hAAAA_AAAA_5AAA_AAAA);
        asserts++;
        if (error_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL amo_error_sticky: got %b required 1", error_o);
        end
    endtask

    task automatic test_reset_mid();
        bp_bedrock_mem_header_s w, r;
        int seen;
        w = mk_hdr(e_bedrock_mem_uc_wr, 40'h180, e_bedrock_msg_size_16, 16'hF001);
        send_beat(w, 64'hCCCC_CCCC_CCCC_CCCC);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        asserts++;
        if (mem_fwd_ready_and_o !== 1'b1 || mem_rev_v_o !== 1'b0 || error_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: ready=%b rev_v=%b error=%b required 1/0/0",
                     mem_fwd_ready_and_o, mem_rev_v_o, error_o);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_rev_v_o) seen++;
            tick();
        end
        asserts++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL mid_no_ack: rev_v cycles=%0d required 0", seen);
        end
        r = mk_hdr(e_bedrock_mem_uc_rd, 40'h180, e_bedrock_msg_size_8, 16'hF002);
        send_beat(r, 64'h0);
        recv_beat("mid_partial", r, 64'hCCCC_CCCC_CCCC_CCCC);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_subfill();
        test_backpressure();
        test_amo_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
